// File: rtl/seq_left_shifter_pkg.sv
// Shared types and constants for the multi-cycle logical left shifter.
// Stage amounts run from the largest weight down, one stage per clock.
package seq_left_shifter_pkg;

    localparam int WIDTH      = 32;
    localparam int SHAMT_W    = 5;
    localparam int NUM_STAGES = 5;

    localparam int STAGE_AMT_0 = 16;
    localparam int STAGE_AMT_1 = 8;
    localparam int STAGE_AMT_2 = 4;
    localparam int STAGE_AMT_3 = 2;
    localparam int STAGE_AMT_4 = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int stage_amt(input int k);
        case (k)
            0:       return STAGE_AMT_0;
            1:       return STAGE_AMT_1;
            2:       return STAGE_AMT_2;
            3:       return STAGE_AMT_3;
            default: return STAGE_AMT_4;
        endcase
    endfunction

endpackage

// File: rtl/seq_left_shifter_lsl_stage.sv
// One constant-amount left-shift stage: zero-filled shift by N plus the OR
// of the N bits that fall off the top.
module lsl_stage
    import seq_left_shifter_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             spill
);

    assign dout  = din << N;
    assign spill = |din[WIDTH-1 -: N];

endmodule

// File: rtl/seq_left_shifter.sv
// Multi-cycle 32-bit logical left shifter with start/ready handshake.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting; outputs hold the last completed result
//   BUSY    | applying one binary-weighted stage (16,8,4,2,1) per clock
//   DONE    | one cycle with data_resultRDY high
module seq_left_shifter
    import seq_left_shifter_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_shift,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] ctrl_shamt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_shiftout,
    output logic               data_resultRDY
);

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] amount;
    logic [2:0]         count;
    logic               acc;

    logic [WIDTH-1:0]   stage_out   [NUM_STAGES];
    logic               stage_spill [NUM_STAGES];
    logic [WIDTH-1:0]   work_next;
    logic               acc_next;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        lsl_stage #(.N(stage_amt(g))) u_stage (
            .din   (work),
            .dout  (stage_out[g]),
            .spill (stage_spill[g])
        );
    end

    // Stage k is enabled by shamt bit (4-k); the counter picks which copy.
    always_comb begin
        work_next = work;
        acc_next  = acc;
        if (state == ST_BUSY) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (count == 3'(k) && amount[SHAMT_W-1-k]) begin
                    work_next = stage_out[k];
                    acc_next  = acc | stage_spill[k];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            work           <= '0;
            amount         <= '0;
            count          <= '0;
            acc            <= 1'b0;
            data_result    <= '0;
            data_shiftout  <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_shift) begin
                // Restart from any state; an in-flight operation is dropped.
                state  <= ST_BUSY;
                work   <= data_operandA;
                amount <= ctrl_shamt;
                count  <= '0;
                acc    <= 1'b0;
            end else begin
                case (state)
                    ST_BUSY: begin
                        work  <= work_next;
                        acc   <= acc_next;
                        count <= count + 3'd1;
                        if (count == 3'(NUM_STAGES - 1)) begin
                            state          <= ST_DONE;
                            data_result    <= work_next;
                            data_shiftout  <= acc_next;
                            data_resultRDY <= 1'b1;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
